// File: rtl/qc_ldpc_pkg.sv
// Shared types and constants for the QC-LDPC encoder front end.
// Holds the frame geometry, the circulant-size selector and the buffer state type,
// plus helpers that turn a circulant selector into a size or a keep mask.
package qc_ldpc_pkg;

    localparam int MAX_Z         = 81;
    localparam int NUM_INFO_BLKS = 20;

    typedef enum logic [1:0] {
        Z27  = 2'd0,
        Z54  = 2'd1,
        Z81  = 2'd2,
        ZRSV = 2'd3
    } z_sel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // The reserved selector falls back to the widest circulant.
    function automatic int z_of(input z_sel_t z);
        case (z)
            Z27:     return 27;
            Z54:     return 54;
            default: return 81;
        endcase
    endfunction

    // One bit per block position; bits at or above Z are cleared.
    function automatic logic [MAX_Z-1:0] z_mask(input z_sel_t z);
        logic [MAX_Z-1:0] m;
        for (int i = 0; i < MAX_Z; i++) begin
            m[i] = (i < z_of(z));
        end
        return m;
    endfunction

endpackage

// File: rtl/qc_ldpc_frame_buf.sv
// One frame buffer of the info loader: block storage, EMPTY/FILL/FULL state and
// the circulant selector captured on the first block of the frame.
module qc_ldpc_frame_buf
    import qc_ldpc_pkg::*;
(
    input  logic                             CLK,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [4:0]                       wr_slot,
    input  logic [MAX_Z-1:0]                 wr_data,
    input  logic                             first_blk,
    input  logic                             last_blk,
    input  logic                             early_end,
    input  z_sel_t                           zsel_in,
    input  logic                             take,
    output buf_state_t                       state,
    output logic [MAX_Z*NUM_INFO_BLKS-1:0]   data,
    output z_sel_t                           z_sel
);

    logic [MAX_Z-1:0] slots [NUM_INFO_BLKS];

    // Store each written block and capture the circulant size on the first block.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_INFO_BLKS; k++) begin
                slots[k] <= '0;
            end
            z_sel <= Z27;
        end else if (wr_en) begin
            slots[wr_slot] <= wr_data;
            if (first_blk) begin
                z_sel <= zsel_in;
            end
        end
    end

    // Buffer lifecycle; a write and a take never hit the same buffer in one cycle
    // because writes need a non-FULL buffer and takes need a FULL one.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else if (wr_en) begin
            if (last_blk) begin
                state <= FULL;
            end else if (early_end) begin
                state <= EMPTY;
            end else if (first_blk) begin
                state <= FILL;
            end
        end else if (take) begin
            state <= EMPTY;
        end
    end

    // Flatten the slots so block k sits at bits [k*MAX_Z +: MAX_Z].
    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_INFO_BLKS; k++) begin
            data[k*MAX_Z +: MAX_Z] = slots[k];
        end
    end

endmodule

// File: rtl/qc_ldpc_info_loader.sv
// Info-block loader for the QC-LDPC encoder: assembles NUM_INFO_BLKS blocks into a
// frame and hands whole frames to the encoder.
// Build option QC_LDPC_LOADER_PINGPONG_EN: when defined, two buffers alternate so
// the next frame loads while the current one is consumed; otherwise one buffer.
module qc_ldpc_info_loader
    import qc_ldpc_pkg::*;
(
    input  logic                             CLK,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [MAX_Z-1:0]                 s_data,
    input  logic                             s_last,
    input  logic [1:0]                       s_z_sel,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [MAX_Z*NUM_INFO_BLKS-1:0]   m_data,
    output logic [1:0]                       m_z_sel,
    output logic                             err_len,
    output logic                             err_zsel
);

    localparam logic [4:0] LAST_BLK = 5'(NUM_INFO_BLKS - 1);

    logic [4:0]                       blk_cnt;
    logic                             beat;
    logic                             take;
    logic                             first_blk;
    logic                             final_blk;
    logic                             early_end;
    z_sel_t                           in_zsel;
    z_sel_t                           eff_zsel;
    z_sel_t                           wr_zsel;
    z_sel_t                           rd_zsel;
    buf_state_t                       wr_state;
    buf_state_t                       rd_state;
    logic [MAX_Z-1:0]                 blk_data;
    logic [MAX_Z*NUM_INFO_BLKS-1:0]   rd_data;

    assign s_ready   = (wr_state != FULL);
    assign m_valid   = (rd_state == FULL);
    assign beat      = s_valid && s_ready;
    assign take      = m_valid && m_ready;
    assign first_blk = (blk_cnt == 5'd0);
    assign final_blk = (blk_cnt == LAST_BLK);
    assign early_end = s_last && !final_blk;
    assign in_zsel   = (s_z_sel == 2'd3) ? Z81 : z_sel_t'(s_z_sel);
    assign eff_zsel  = first_blk ? in_zsel : wr_zsel;
    assign blk_data  = s_data & z_mask(eff_zsel);
    assign m_data    = rd_data;
    assign m_z_sel   = rd_zsel;

`ifdef QC_LDPC_LOADER_PINGPONG_EN
    logic                             wr_sel;
    logic                             rd_sel;
    buf_state_t                       state_a;
    buf_state_t                       state_b;
    z_sel_t                           zsel_a;
    z_sel_t                           zsel_b;
    logic [MAX_Z*NUM_INFO_BLKS-1:0]   data_a;
    logic [MAX_Z*NUM_INFO_BLKS-1:0]   data_b;

    qc_ldpc_frame_buf u_buf_a (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .wr_en     (beat && !wr_sel),
        .wr_slot   (blk_cnt),
        .wr_data   (blk_data),
        .first_blk (first_blk),
        .last_blk  (final_blk),
        .early_end (early_end),
        .zsel_in   (in_zsel),
        .take      (take && !rd_sel),
        .state     (state_a),
        .data      (data_a),
        .z_sel     (zsel_a)
    );

    qc_ldpc_frame_buf u_buf_b (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .wr_en     (beat && wr_sel),
        .wr_slot   (blk_cnt),
        .wr_data   (blk_data),
        .first_blk (first_blk),
        .last_blk  (final_blk),
        .early_end (early_end),
        .zsel_in   (in_zsel),
        .take      (take && rd_sel),
        .state     (state_b),
        .data      (data_b),
        .z_sel     (zsel_b)
    );

    assign wr_state = wr_sel ? state_b : state_a;
    assign wr_zsel  = wr_sel ? zsel_b  : zsel_a;
    assign rd_state = rd_sel ? state_b : state_a;
    assign rd_zsel  = rd_sel ? zsel_b  : zsel_a;
    assign rd_data  = rd_sel ? data_b  : data_a;

    // Writer moves on after a completed frame, reader after a consumed one,
    // which keeps frames leaving in the order they arrived.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (beat && final_blk) begin
                wr_sel <= ~wr_sel;
            end
            if (take) begin
                rd_sel <= ~rd_sel;
            end
        end
    end
`else
    buf_state_t                       state_a;
    z_sel_t                           zsel_a;
    logic [MAX_Z*NUM_INFO_BLKS-1:0]   data_a;

    qc_ldpc_frame_buf u_buf_a (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .wr_en     (beat),
        .wr_slot   (blk_cnt),
        .wr_data   (blk_data),
        .first_blk (first_blk),
        .last_blk  (final_blk),
        .early_end (early_end),
        .zsel_in   (in_zsel),
        .take      (take),
        .state     (state_a),
        .data      (data_a),
        .z_sel     (zsel_a)
    );

    assign wr_state = state_a;
    assign wr_zsel  = zsel_a;
    assign rd_state = state_a;
    assign rd_zsel  = zsel_a;
    assign rd_data  = data_a;
`endif

    // Slot counter plus registered error pulses for length and reserved-size faults.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt  <= 5'd0;
            err_len  <= 1'b0;
            err_zsel <= 1'b0;
        end else begin
            err_len  <= beat && (final_blk ? !s_last : s_last);
            err_zsel <= beat && first_blk && (s_z_sel == 2'd3);
            if (beat) begin
                blk_cnt <= (final_blk || s_last) ? 5'd0 : blk_cnt + 5'd1;
            end
        end
    end

endmodule
